// File: rtl/mcpu_pkg.sv
// mcpu_pkg: opcodes, FSM states and microword layout shared by the mcpu core.
package mcpu_pkg;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_STA = 4'h3;
   localparam logic [3:0] OP_LDI = 4'h4;
   localparam logic [3:0] OP_JMP = 4'h5;
   localparam logic [3:0] OP_JZ  = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_OUT = 4'h8;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_T3   = 3'd3,
      S_T4   = 3'd4,
      S_T5   = 3'd5,
      S_T6   = 3'd6,
      S_HALT = 3'd7
   } state_t;

   // Microword bits: E* drive the internal bus, L* load a register from it.
   localparam int U_EP   = 0;   // PC -> bus
   localparam int U_CP   = 1;   // PC increment
   localparam int U_LM   = 2;   // bus -> MAR
   localparam int U_CE   = 3;   // RAM[MAR] -> bus
   localparam int U_LI   = 4;   // bus -> IR
   localparam int U_EI   = 5;   // IR operand (zero-extended) -> bus
   localparam int U_LA   = 6;   // bus -> ACC
   localparam int U_EA   = 7;   // ACC -> bus
   localparam int U_LB   = 8;   // bus -> B
   localparam int U_SU   = 9;   // ALU subtracts
   localparam int U_EU   = 10;  // ALU result -> bus, flags update
   localparam int U_LO   = 11;  // bus -> output register
   localparam int U_WR   = 12;  // bus -> RAM[MAR]
   localparam int U_JP   = 13;  // bus -> PC, qualified by the jump condition
   localparam int U_DONE = 14;  // last micro-step of the instruction
   localparam int U_HALT = 15;  // enter HALT
   localparam int UW     = 16;

   typedef logic [UW-1:0] uword_t;

   // Micro-step number reported on t_state: 0 outside T1..T6.
   function automatic logic [2:0] step_num(input state_t s);
      logic [2:0] n;
      case (s)
         S_T1:    n = 3'd1;
         S_T2:    n = 3'd2;
         S_T3:    n = 3'd3;
         S_T4:    n = 3'd4;
         S_T5:    n = 3'd5;
         S_T6:    n = 3'd6;
         default: n = 3'd0;
      endcase
      return n;
   endfunction

   // Control ROM indexed by {opcode, micro-step}; fetch rows are opcode-independent.
   function automatic uword_t ucode(input logic [3:0] op, input logic [2:0] t);
      uword_t w;
      w = '0;
      case (t)
         3'd1: begin w[U_EP] = 1'b1; w[U_LM] = 1'b1; end
         3'd2: w[U_CP] = 1'b1;
         3'd3: begin w[U_CE] = 1'b1; w[U_LI] = 1'b1; end
         3'd4: begin
            case (op)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin w[U_EI] = 1'b1; w[U_LM] = 1'b1; end
               OP_LDI:              begin w[U_EI] = 1'b1; w[U_LA] = 1'b1; w[U_DONE] = 1'b1; end
               OP_JMP, OP_JZ, OP_JC: begin w[U_EI] = 1'b1; w[U_JP] = 1'b1; w[U_DONE] = 1'b1; end
               OP_OUT:              begin w[U_EA] = 1'b1; w[U_LO] = 1'b1; w[U_DONE] = 1'b1; end
               OP_HLT:              w[U_HALT] = 1'b1;
               default:             w[U_DONE] = 1'b1;
            endcase
         end
         3'd5: begin
            case (op)
               OP_LDA:         begin w[U_CE] = 1'b1; w[U_LA] = 1'b1; w[U_DONE] = 1'b1; end
               OP_ADD, OP_SUB: begin w[U_CE] = 1'b1; w[U_LB] = 1'b1; end
               OP_STA:         begin w[U_EA] = 1'b1; w[U_WR] = 1'b1; w[U_DONE] = 1'b1; end
               default:        w[U_DONE] = 1'b1;
            endcase
         end
         3'd6: begin
            case (op)
               OP_ADD:  begin w[U_EU] = 1'b1; w[U_LA] = 1'b1; w[U_DONE] = 1'b1; end
               OP_SUB:  begin w[U_EU] = 1'b1; w[U_SU] = 1'b1; w[U_LA] = 1'b1; w[U_DONE] = 1'b1; end
               default: w[U_DONE] = 1'b1;
            endcase
         end
         default: ;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/mcpu_param_core_if.sv
// mcpu_param_core_if: program loader port and output register of the core.
interface mcpu_param_core_if #(
   parameter int DW = 8,
   parameter int AW = 4
);
   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [DW-1:0] prog_data;
   logic [DW-1:0] out_data;
   logic          out_valid;

   modport master (
      output prog_we, prog_addr, prog_data,
      input  out_data, out_valid
   );

   modport slave (
      input  prog_we, prog_addr, prog_data,
      output out_data, out_valid
   );
endinterface

// File: rtl/mcpu_ram.sv
// mcpu_ram: 2**AW x DW program/data store, asynchronous read, synchronous write.
module mcpu_ram #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   // Single write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mcpu_param_core.sv
// mcpu_param_core: microprogrammed accumulator CPU with on-core RAM and loader.
module mcpu_param_core
   import mcpu_pkg::*;
#(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   mcpu_param_core_if.slave host,
   output logic [AW-1:0]   pc,
   output logic [DW-1:0]   acc,
   output logic            zf,
   output logic            cf,
   output logic [2:0]      t_state,
   output logic            busy,
   output logic            halted
);

   state_t        state, state_nxt;
   logic [AW-1:0] mar;
   logic [3:0]    ir_op;
   logic [AW-1:0] ir_arg;
   logic [DW-1:0] b_reg;
   logic [DW-1:0] out_q;
   logic          out_v;

   uword_t        uw;
   logic [DW-1:0] dbus;
   logic [DW-1:0] ram_rd;
   logic [DW-1:0] b_op;
   logic [DW-1:0] alu_y;
   logic          alu_c;
   logic          jmp_ok;
   logic          pc_ld;
   logic          in_idle;
   logic          ram_we;
   logic [AW-1:0] ram_waddr;
   logic [DW-1:0] ram_wdata;

   // Status decode and the active microword (all-zero outside T1..T6).
   always_comb begin
      t_state = step_num(state);
      busy    = (t_state != 3'd0);
      halted  = (state == S_HALT);
      in_idle = (state == S_IDLE);
      uw      = busy ? ucode(ir_op, t_state) : '0;
   end

   // Internal bus source select; each micro-step enables at most one source.
   always_comb begin
      dbus = '0;
      if (uw[U_EP])      dbus = DW'(pc);
      else if (uw[U_CE]) dbus = ram_rd;
      else if (uw[U_EI]) dbus = DW'(ir_arg);
      else if (uw[U_EA]) dbus = acc;
      else if (uw[U_EU]) dbus = alu_y;
   end

   // Adder: subtraction is ACC + ~B + 1, so carry set means no borrow.
   always_comb begin
      b_op = uw[U_SU] ? ~b_reg : b_reg;
      {alu_c, alu_y} = {1'b0, acc} + {1'b0, b_op} + (DW+1)'(uw[U_SU]);
   end

   // Jump qualification applied to the JP bit.
   always_comb begin
      case (ir_op)
         OP_JZ:   jmp_ok = zf;
         OP_JC:   jmp_ok = cf;
         default: jmp_ok = 1'b1;
      endcase
      pc_ld = uw[U_JP] & jmp_ok;
   end

   // RAM write port shared by the loader (IDLE only) and STA; reset cancels both.
   always_comb begin
      ram_we    = ~rst & ((in_idle & host.prog_we) | uw[U_WR]);
      ram_waddr = in_idle ? host.prog_addr : mar;
      ram_wdata = in_idle ? host.prog_data : dbus;
   end

   mcpu_ram #(.DW(DW), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (mar),
      .rdata (ram_rd)
   );

   // Next state: fixed micro-step sequence, cut short by DONE or HALT.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (run) state_nxt = S_T1;
         S_T1:    state_nxt = S_T2;
         S_T2:    state_nxt = S_T3;
         S_T3:    state_nxt = S_T4;
         S_T4:    state_nxt = S_T5;
         S_T5:    state_nxt = S_T6;
         S_T6:    state_nxt = S_T1;
         default: state_nxt = S_HALT;
      endcase
      if (uw[U_HALT])      state_nxt = S_HALT;
      else if (uw[U_DONE]) state_nxt = S_T1;
   end

   // State register and datapath registers driven by the microword.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         pc     <= '0;
         mar    <= '0;
         ir_op  <= '0;
         ir_arg <= '0;
         acc    <= '0;
         b_reg  <= '0;
         zf     <= 1'b0;
         cf     <= 1'b0;
         out_q  <= '0;
         out_v  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (uw[U_LM]) mar <= dbus[AW-1:0];
         if (uw[U_CP])  pc <= pc + AW'(1);
         else if (pc_ld) pc <= dbus[AW-1:0];
         if (uw[U_LI]) begin
            ir_op  <= dbus[DW-1:DW-4];
            ir_arg <= dbus[AW-1:0];
         end
         if (uw[U_LA]) acc   <= dbus;
         if (uw[U_LB]) b_reg <= dbus;
         if (uw[U_EU]) begin
            cf <= alu_c;
            zf <= (alu_y == '0);
         end
         if (uw[U_LO]) out_q <= dbus;
         out_v <= uw[U_LO];
      end
   end

   assign host.out_data  = out_q;
   assign host.out_valid = out_v;

endmodule

// File: tb/tb_mcpu_param_core.sv
// tb_mcpu_param_core: ISA-level reference model against the 8/4 core, plus a 12/6 variant.
module tb_mcpu_param_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, run;
   logic [3:0] pc;
   logic [7:0] acc;
   logic       zf, cf, busy, halted;
   logic [2:0] t_state;

   logic        rst12, run12;
   logic [5:0]  pc12;
   logic [11:0] acc12;
   logic        zf12, cf12, busy12, halted12;
   logic [2:0]  ts12;

   mcpu_param_core_if #(.DW(8), .AW(4)) bus8 ();
   mcpu_param_core_if #(.DW(12), .AW(6)) bus12 ();

   mcpu_param_core #(.DW(8), .AW(4)) u_dut (
      .clk(clk), .rst(rst), .run(run), .host(bus8),
      .pc(pc), .acc(acc), .zf(zf), .cf(cf),
      .t_state(t_state), .busy(busy), .halted(halted)
   );

   mcpu_param_core #(.DW(12), .AW(6)) u_dut12 (
      .clk(clk), .rst(rst12), .run(run12), .host(bus12),
      .pc(pc12), .acc(acc12), .zf(zf12), .cf(cf12),
      .t_state(ts12), .busy(busy12), .halted(halted12)
   );

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: one call executes one whole instruction.
   int m_mem [16];
   int m_acc, m_pc, m_z, m_c, m_out;
   int cyc, ov_cyc, halt_cyc;
   logic [7:0] prog [16];

   task automatic model_reset;
      m_acc = 0; m_pc = 0; m_z = 0; m_c = 0; m_out = 0;
   endtask

   task automatic model_step(output int n, output bit is_out, output bit is_hlt);
      int w, op, a;
      w = m_mem[m_pc];
      op = w / 16;
      a = w % 16;
      m_pc = (m_pc + 1) % 16;
      n = 4; is_out = 0; is_hlt = 0;
      case (op)
         0: begin m_acc = m_mem[a]; n = 5; end
         1: begin
            w = m_acc + m_mem[a];
            m_c = (w > 255) ? 1 : 0;
            m_acc = w % 256;
            m_z = (m_acc == 0) ? 1 : 0;
            n = 6;
         end
         2: begin
            m_c = (m_acc >= m_mem[a]) ? 1 : 0;
            m_acc = (m_acc - m_mem[a] + 256) % 256;
            m_z = (m_acc == 0) ? 1 : 0;
            n = 6;
         end
         3: begin m_mem[a] = m_acc; n = 5; end
         4: m_acc = a;
         5: m_pc = a;
         6: if (m_z != 0) m_pc = a;
         7: if (m_c != 0) m_pc = a;
         8: begin m_out = m_acc; is_out = 1; end
         15: is_hlt = 1;
         default: ;
      endcase
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; run = 1'b0; bus8.prog_we = 1'b0;
      tick; tick;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic clear_prog;
      for (int i = 0; i < 16; i++) prog[i] = 8'h00;
   endtask

   task automatic load_prog;
      for (int i = 0; i < 16; i++) begin
         bus8.prog_we = 1'b1;
         bus8.prog_addr = 4'(i);
         bus8.prog_data = prog[i];
         tick;
         m_mem[i] = int'(prog[i]);
      end
      bus8.prog_we = 1'b0;
   endtask

   // Run up to max_instr instructions, checking every cycle and every boundary.
   task automatic run_check(input int max_instr, input bit inj);
      int n;
      bit is_out, is_hlt;
      ov_cyc = 0; halt_cyc = 0;
      run = 1'b1;
      tick; cyc = 1;
      chk("start_t1", t_state, 1);
      chk("start_ov", bus8.out_valid, 0);
      for (int i = 0; i < max_instr; i++) begin
         model_step(n, is_out, is_hlt);
         for (int k = 1; k <= n; k++) begin
            tick; cyc++;
            bus8.prog_we = 1'b0;
            chk("ov", bus8.out_valid, (k == n && is_out) ? 1 : 0);
            if (bus8.out_valid === 1'b1) ov_cyc = cyc;
            if (inj && i == 0 && k == 1) begin
               chk("inj_t2", t_state, 2);
               bus8.prog_we = 1'b1;
               bus8.prog_addr = 4'hE;
               bus8.prog_data = 8'h77;
            end
         end
         chk("pc", pc, m_pc);
         chk("acc", acc, m_acc);
         chk("zf", zf, m_z);
         chk("cf", cf, m_c);
         chk("out_data", bus8.out_data, m_out);
         chk("t_state", t_state, is_hlt ? 0 : 1);
         chk("halted", halted, is_hlt ? 1 : 0);
         if (is_hlt) begin
            halt_cyc = cyc;
            tick; tick; tick;
            chk("halt_hold", halted, 1);
            chk("halt_busy", busy, 0);
            chk("halt_pc", pc, m_pc);
            break;
         end
      end
      run = 1'b0;
   endtask

   int opt [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 15};
   int a12 [6]  = '{0, 1, 2, 63, 32, 33};
   int d12 [6]  = '{'h020, 'h121, 'h53F, 'h900, 'hFFF, 'h001};

   initial begin
      rst = 1'b1; run = 1'b0;
      bus8.prog_we = 1'b0; bus8.prog_addr = '0; bus8.prog_data = '0;
      rst12 = 1'b1; run12 = 1'b0;
      bus12.prog_we = 1'b0; bus12.prog_addr = '0; bus12.prog_data = '0;

      // Reset state and idle hold
      do_reset();
      chk("rst_pc", pc, 0);
      chk("rst_acc", acc, 0);
      chk("rst_zf", zf, 0);
      chk("rst_cf", cf, 0);
      chk("rst_out", bus8.out_data, 0);
      chk("rst_ov", bus8.out_valid, 0);
      chk("rst_t", t_state, 0);
      chk("rst_busy", busy, 0);
      chk("rst_halt", halted, 0);
      repeat (10) tick;
      chk("idle_t", t_state, 0);
      chk("idle_pc", pc, 0);
      chk("idle_busy", busy, 0);

      // Reference program: 0x10 + 0x14 -> OUT -> HLT
      clear_prog();
      prog[0] = 8'h09; prog[1] = 8'h1A; prog[2] = 8'h80; prog[3] = 8'hF0;
      prog[9] = 8'h10; prog[10] = 8'h14;
      load_prog();
      run_check(10, 1'b0);
      chk("ov_cycle", ov_cyc, 16);
      chk("halt_cycle", halt_cyc, 20);
      chk("prog_out", bus8.out_data, 8'h24);
      chk("prog_pc", pc, 4);

      // Reset during T5 of ADD, then rerun from retained RAM
      do_reset();
      run = 1'b1;
      tick;
      repeat (9) tick;
      chk("mid_t5", t_state, 5);
      chk("mid_acc", acc, 8'h10);
      rst = 1'b1;
      tick;
      chk("mid_rst_acc", acc, 0);
      chk("mid_rst_t", t_state, 0);
      chk("mid_rst_pc", pc, 0);
      rst = 1'b0; run = 1'b0;
      model_reset();
      run_check(10, 1'b0);
      chk("rerun_ov_cycle", ov_cyc, 16);
      chk("rerun_out", bus8.out_data, 8'h24);

      // SUB flags with conditional jumps
      do_reset();
      clear_prog();
      prog[0] = 8'h45; prog[1] = 8'h28; prog[2] = 8'h76; prog[3] = 8'h47;
      prog[4] = 8'h28; prog[5] = 8'h69; prog[6] = 8'hF0; prog[8] = 8'h07;
      prog[9] = 8'h80; prog[10] = 8'hF0;
      load_prog();
      run_check(20, 1'b0);
      chk("sub_pc", pc, 4'hB);
      chk("sub_zf", zf, 1);
      chk("sub_cf", cf, 1);

      // PC wrap via JMP to 0xF and a not-taken JZ
      do_reset();
      clear_prog();
      prog[0] = 8'h1D; prog[1] = 8'h65; prog[2] = 8'h5F; prog[5] = 8'hF0;
      prog[13] = 8'h01; prog[15] = 8'h90;
      load_prog();
      run_check(8, 1'b0);
      chk("wrap_acc", acc, 2);
      chk("wrap_pc", pc, 0);

      // STA/LDA round trip; loader strobe during T2 must be ignored
      do_reset();
      clear_prog();
      prog[0] = 8'h49; prog[1] = 8'h3C; prog[2] = 8'h40; prog[3] = 8'h0C;
      prog[4] = 8'h80; prog[5] = 8'h0E; prog[6] = 8'h80; prog[7] = 8'hF0;
      prog[14] = 8'h33;
      load_prog();
      run_check(12, 1'b1);
      chk("sta_out", bus8.out_data, 8'h33);

      // Random programs
      for (int r = 0; r < 8; r++) begin
         do_reset();
         for (int a = 0; a < 16; a++)
            prog[a] = 8'((opt[$urandom_range(10)] * 16) + int'($urandom_range(15)));
         load_prog();
         run_check(30, 1'b0);
      end

      // DW=12, AW=6 variant: carry/zero at full width and 6-bit PC wrap
      rst12 = 1'b1; tick; tick; rst12 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus12.prog_we = 1'b1;
         bus12.prog_addr = 6'(a12[i]);
         bus12.prog_data = 12'(d12[i]);
         tick;
      end
      bus12.prog_we = 1'b0;
      run12 = 1'b1;
      tick;
      chk("v_t1", ts12, 1);
      repeat (11) tick;
      chk("v_acc", acc12, (32'hFFF + 32'h1) % 32'h1000);
      chk("v_cf", cf12, (32'hFFF + 32'h1) / 32'h1000);
      chk("v_zf", zf12, 1);
      chk("v_t", ts12, 1);
      repeat (4) tick;
      chk("v_jmp_pc", pc12, (1 << 6) - 1);
      repeat (2) tick;
      chk("v_wrap_pc", pc12, 0);
      repeat (2) tick;
      chk("v_wrap_t", ts12, 1);
      run12 = 1'b0;

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/mcpu_param_core.md
# mcpu_param_core

Parametrised horizontal-microprogrammed accumulator CPU. It is the successor to the 8-bit SAP-1 core, with configurable data and address widths, an on-core program/data RAM with a loader port, and an extended instruction set: store, immediate load, unconditional and conditional jumps, Z/C flags, and halt. Each instruction terminates early once its last micro-step completes. It sits as the compute core of the SAP-class processors, with the loader driven by the testbench or the boot logic.

## Interface
- `DW`, default 8: data/instruction width; must satisfy `DW >= AW+4`.
- `AW`, default 4: address width; RAM depth is 2**AW.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  level; when high in IDLE, execution starts at the next edge.
- `prog_we`  in  1  loader write strobe; honoured only in IDLE.
- `prog_addr`  in  AW  loader address.
- `prog_data`  in  DW  loader data.
- `pc`  out  AW  program counter.
- `acc`  out  DW  accumulator.
- `zf`, `cf`  out  1 each  zero flag and carry flag.
- `out_data`  out  DW  output register.
- `out_valid`  out  1  one-cycle pulse when the OUT instruction writes `out_data`.
- `t_state`  out  3  current micro-step: 0 = IDLE/HALT, 1..6 = T1..T6.
- `busy`  out  1  high in T1..T6.
- `halted`  out  1  high in HALT.

## Operation
- Instruction format: `[DW-1:DW-4]` is the opcode; `[AW-1:0]` is the operand address or immediate. Bits in between are ignored.
- Opcodes: 0 LDA, 1 ADD, 2 SUB, 3 STA, 4 LDI, 5 JMP, 6 JZ, 7 JC, 8 OUT, F HLT. All other opcodes execute as NOP.
- States: IDLE, T1..T6, HALT.
  - IDLE→T1 when `run` is high.
  - Each instruction ends when its micro-step has the done bit set; the next state is T1.
  - HLT→HALT. HALT is left only by `rst`.
- Fetch:
  - T1: MAR←PC.
  - T2: PC←PC+1, mod 2**AW (15 wraps to 0 at default width).
  - T3: IR←RAM[MAR].
- Execute, with total cycles per instruction:
  - LDA: T4 MAR←addr; T5 ACC←RAM[MAR], done. 5 cycles.
  - ADD/SUB: T4 MAR←addr; T5 B←RAM[MAR]; T6 ACC←ACC±B, flags update, done. 6 cycles.
  - STA: T4 MAR←addr; T5 RAM[MAR]←ACC, done. 5 cycles.
  - LDI: T4 ACC←zero-extended operand, done. 4 cycles.
  - JMP: T4 PC←addr, done. JZ and JC do the same only if `zf` or `cf` is set respectively; otherwise done with no change. 4 cycles.
  - OUT: T4 out_data←ACC, `out_valid`=1 during the following cycle, done. 4 cycles.
  - NOP: T4 done. 4 cycles.
  - HLT: T4 next state HALT. 4 cycles.
- Arithmetic: modulo 2**DW.
  - ADD: C = carry out.
  - SUB: computed as ACC + ~B + 1; C = carry out, so C=1 means no borrow.
  - Z = (result == 0).
  - Only ADD and SUB modify the flags.
- RAM: asynchronous read from MAR, synchronous write. STA and loader writes never coincide, because the loader works only in IDLE.

## Timing
- Reset values:
  - PC, MAR, IR, ACC, B, `out_data` = 0.
  - `zf`, `cf`, `out_valid`, `busy`, `halted` = 0; `t_state` = 0; state = IDLE.
  - RAM contents are not cleared.
- `rst` overrides everything, including mid-instruction. A write scheduled for the same edge (STA, flag update) is discarded.
- `prog_we` in any state other than IDLE is ignored.
- Dropping `run` mid-program has no effect; only `rst` returns the core to IDLE.
- `out_valid` is registered: it is high for exactly the one cycle after the T4 edge of OUT.
- Back-to-back instructions have no idle cycle between them: done→T1 on the next edge.

## Structure
- Package `mcpu_pkg` holds:
  - opcode localparams;
  - the state enum;
  - microword bit positions: EP, CP, LM, CE, LI, EI, LA, EA, LB, SU, EU, LO, WR, JP, DONE, HALT.
- Control is a microword ROM indexed by {opcode, t_state}, with jump conditioning applied on the JP bit.
- Sub-module `mcpu_ram` (2**AW × DW, async read, sync write, write port muxed between loader and STA).

## Test plan
- Reset: after `rst` is released, all outputs are 0 and `t_state`=0. With `run` low for 10 cycles, nothing changes.
- Program run: load [0]=0x09, [1]=0x1A, [2]=0x80, [3]=0xF0, [9]=0x10, [A]=0x14, then raise `run`.
  - `out_data`=0x24, with `out_valid` a single pulse in cycle 16 after start.
  - `halted`=1 from cycle 20 onward.
  - `pc`=4.
- SUB flags:
  - 0x05−0x07 → ACC=0xFE, C=0, Z=0.
  - 0x07−0x07 → ACC=0x00, C=1, Z=1.
  - A following JZ is taken; a following JC after the first case is not taken.
- Wrap and jumps: JMP to 0xF, [F]=NOP. PC wraps to 0 and re-executes [0]. A JZ with Z=0 falls through in 4 cycles.
- STA/loader: STA 0xC, then LDA 0xC returns the stored value. A `prog_we` pulse during T2 leaves RAM unchanged.
- Reset mid-ADD at T5: on the next cycle ACC=0 and the state is IDLE. The previously loaded RAM is retained, and the program re-runs identically.
- Parameter variant DW=12, AW=6: ADD 0xFFF+0x001 → 0x000, C=1, Z=1. PC wraps from 63 to 0.
